// File: rtl/div_pkg.sv
// Shared definitions for the divider front-end: datapath width and FSM states.
package div_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/divider_unsigned.sv
// Combinational restoring unsigned divider; driven from registered operands and
// timed as a multicycle path by its caller.
module divider_unsigned
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] i_dividend,
  input  logic [DIV_W-1:0] i_divisor,
  output logic [DIV_W-1:0] o_quotient,
  output logic [DIV_W-1:0] o_remainder
);

  logic [DIV_W:0]   rem;
  logic [DIV_W-1:0] quo;

  // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
  always_comb begin
    rem = '0;
    quo = '0;
    for (int i = DIV_W - 1; i >= 0; i--) begin
      rem = {rem[DIV_W-1:0], i_dividend[i]};
      if (rem >= {1'b0, i_divisor}) begin
        rem    = rem - {1'b0, i_divisor};
        quo[i] = 1'b1;
      end
    end
    o_quotient  = quo;
    o_remainder = rem[DIV_W-1:0];
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin front-end for the shared unsigned divider: accepts one request,
// holds operands MC_CYCLES clocks, then returns the result over valid/ready.
module div_arbiter
  import div_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MC_CYCLES = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ*DIV_W-1:0] i_req_dividend,
  input  logic [NUM_REQ*DIV_W-1:0] i_req_divisor,
  output logic [NUM_REQ-1:0]       o_rsp_valid,
  input  logic [NUM_REQ-1:0]       i_rsp_ready,
  output logic [DIV_W-1:0]         o_rsp_quotient,
  output logic [DIV_W-1:0]         o_rsp_remainder,
  output logic                     o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

  state_t             state;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   last;
  logic [CNT_W-1:0]   cnt;
  logic [DIV_W-1:0]   op_dividend;
  logic [DIV_W-1:0]   op_divisor;
  logic [DIV_W-1:0]   res_quotient;
  logic [DIV_W-1:0]   res_remainder;
  logic [DIV_W-1:0]   div_quotient;
  logic [DIV_W-1:0]   div_remainder;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [DIV_W-1:0]   sel_dividend;
  logic [DIV_W-1:0]   sel_divisor;

  // Returns {found, index} of the first valid requester after ptr, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDX_W-1:0]   ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    {win_found, win_idx} = rr_pick(i_req_valid, last);
  end

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_dividend = i_req_dividend[i*DIV_W +: DIV_W];
        sel_divisor  = i_req_divisor[i*DIV_W +: DIV_W];
      end
    end
  end

  // Ready depends only on state and request valids, never on the divider.
  always_comb begin
    o_req_ready = '0;
    if (state == IDLE && win_found) o_req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    o_rsp_valid = '0;
    if (state == RESP) o_rsp_valid[grant] = 1'b1;
  end

  assign o_rsp_quotient  = res_quotient;
  assign o_rsp_remainder = res_remainder;
  assign o_busy          = (state != IDLE);

  divider_unsigned u_divider (
    .i_dividend  (op_dividend),
    .i_divisor   (op_divisor),
    .o_quotient  (div_quotient),
    .o_remainder (div_remainder)
  );

  // Operands change only on accept, so the divider sees stable inputs through CALC.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      last          <= IDX_W'(NUM_REQ - 1);
      cnt           <= '0;
      op_dividend   <= '0;
      op_divisor    <= '0;
      res_quotient  <= '0;
      res_remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            op_dividend <= sel_dividend;
            op_divisor  <= sel_divisor;
            grant       <= win_idx;
            cnt         <= CNT_W'(MC_CYCLES - 1);
            state       <= CALC;
          end
        end
        CALC: begin
          if (cnt == '0) begin
            res_quotient  <= div_quotient;
            res_remainder <= div_remainder;
            state         <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready[grant]) begin
            last  <= grant;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: a cycle-level reference model predicts
// ready/valid/busy and expected results; a monitor checks the response channel.
module tb_div_arbiter;

  localparam int N  = 2;
  localparam int MC = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_dividend = '0;
  logic [N*32-1:0] req_divisor = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [31:0]     rsp_q;
  logic [31:0]     rsp_r;
  logic            busy;

  logic [1:0]      c1_valid = '0;
  logic [1:0]      c1_ready;
  logic [63:0]     c1_dividend = '0;
  logic [63:0]     c1_divisor = '0;
  logic [1:0]      c1_rsp_valid;
  logic [1:0]      c1_rsp_ready = '0;
  logic [31:0]     c1_q;
  logic [31:0]     c1_r;
  logic            c1_busy;

  div_arbiter #(.NUM_REQ(N), .MC_CYCLES(MC)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_dividend(req_dividend), .i_req_divisor(req_divisor),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_quotient(rsp_q), .o_rsp_remainder(rsp_r), .o_busy(busy)
  );

  div_arbiter #(.NUM_REQ(2), .MC_CYCLES(1)) dut_mc1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(c1_valid), .o_req_ready(c1_ready),
    .i_req_dividend(c1_dividend), .i_req_divisor(c1_divisor),
    .o_rsp_valid(c1_rsp_valid), .i_rsp_ready(c1_rsp_ready),
    .o_rsp_quotient(c1_q), .o_rsp_remainder(c1_r), .o_busy(c1_busy)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [31:0] q; logic [31:0] r; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; } op_t;

  exp_t sb_q[$];
  op_t  req_q[N][$];

  int n_checks = 0;
  int n_pass   = 0;
  int rsp_mode = 1;

  bit   m_busy = 1'b0;
  int   m_t = 0;
  int   m_g = 0;
  int   m_last = N - 1;
  int   m_hs_g = -1;
  bit   m_fire = 1'b0;
  logic [N-1:0] acc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t ref_div(input int idx, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.idx = idx;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Reference model: one in-flight operation, round-robin from the last completed requester.
  always @(negedge clk) begin
    logic [N-1:0] er;
    logic [N-1:0] ev;
    int w;
    int c;
    if (!rst_n) begin
      m_busy = 1'b0; m_last = N - 1; m_hs_g = -1; m_fire = 1'b0; m_t = 0; m_g = 0;
      sb_q.delete();
    end else begin
      if (m_fire) begin
        m_busy = 1'b0;
        m_last = m_g;
      end else if (m_hs_g >= 0) begin
        m_busy = 1'b1;
        m_g = m_hs_g;
        m_t = 0;
      end else if (m_busy && m_t < 1000) begin
        m_t++;
      end
      er = '0;
      w = -1;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (w < 0 && req_valid[c]) w = c;
        end
      end
      if (w >= 0) er[w] = 1'b1;
      ev = '0;
      if (m_busy && m_t >= MC) ev[m_g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      chk("busy", 64'(busy), 64'(m_busy));
      m_hs_g = w;
      if (w >= 0) sb_q.push_back(ref_div(w, req_dividend[w*32 +: 32], req_divisor[w*32 +: 32]));
      m_fire = (ev != 0) && rsp_ready[m_g];
    end
  end

  // Monitor: compares every presented response (and its stability) against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid != 0) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb_q[0];
        chk("rsp_idx", 64'(rsp_valid), 64'(1 << e.idx));
        chk("rsp_quotient", 64'(rsp_q), 64'(e.q));
        chk("rsp_remainder", 64'(rsp_r), 64'(e.r));
        if ((rsp_valid & rsp_ready) != 0) void'(sb_q.pop_front());
      end
    end
  end

  always @(negedge clk) acc = rst_n ? (req_valid & req_ready) : '0;

  // Requester driver: holds valid and operands until accepted.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        req_valid[i] = 1'b0;
      end else begin
        if (acc[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
        if (req_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_dividend[i*32 +: 32] = req_q[i][0].a;
          req_divisor[i*32 +: 32]  = req_q[i][0].b;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    case (rsp_mode)
      0: rsp_ready = '0;
      1: rsp_ready = '1;
      default: rsp_ready = N'($urandom);
    endcase
  end

  task automatic push_op(input int idx, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.a = a;
    o.b = b;
    req_q[idx].push_back(o);
  endtask

  task automatic wait_done(input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (n < budget && !done) begin
      @(negedge clk);
      #1;
      if (req_q[0].size() == 0 && req_q[1].size() == 0 && req_valid == 0 &&
          !m_busy && m_hs_g < 0 && sb_q.size() == 0) done = 1'b1;
      n++;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic c1_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er);
    @(posedge clk); #1;
    c1_valid = 2'(1 << idx);
    c1_dividend[idx*32 +: 32] = a;
    c1_divisor[idx*32 +: 32]  = b;
    @(negedge clk);
    chk("mc1_req_ready", 64'(c1_ready), 64'(1 << idx));
    @(posedge clk); #1;
    c1_valid = '0;
    @(negedge clk);
    chk("mc1_calc_valid", 64'(c1_rsp_valid), 64'd0);
    chk("mc1_calc_busy", 64'(c1_busy), 64'd1);
    @(negedge clk);
    chk("mc1_rsp_valid", 64'(c1_rsp_valid), 64'(1 << idx));
    chk("mc1_quotient", 64'(c1_q), 64'(eq));
    chk("mc1_remainder", 64'(c1_r), 64'(er));
    @(posedge clk); #1;
    c1_rsp_ready = 2'b11;
    @(posedge clk); #1;
    c1_rsp_ready = 2'b00;
    @(negedge clk);
    chk("mc1_done_valid", 64'(c1_rsp_valid), 64'd0);
    chk("mc1_done_busy", 64'(c1_busy), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  hit;
    logic [31:0] a;
    logic [31:0] b;

    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_quotient", 64'(rsp_q), 64'd0);
    chk("rst_remainder", 64'(rsp_r), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    rsp_mode = 1;
    push_op(0, 32'd100, 32'd7);
    wait_done(100);

    for (int i = 0; i < 3; i++) begin
      push_op(0, 32'd20, 32'd3);
      push_op(1, 32'd9, 32'd2);
    end
    wait_done(200);

    push_op(1, 32'h1234_5678, 32'd0);
    wait_done(100);

    rsp_mode = 0;
    push_op(0, 32'd1000, 32'd33);
    push_op(1, 32'd77, 32'd7);
    repeat (MC + 7) @(negedge clk);
    rsp_mode = 1;
    wait_done(100);

    push_op(0, 32'd77, 32'd3);
    n = 0;
    hit = 1'b0;
    while (n < 50 && !hit) begin
      @(negedge clk); #1;
      if (m_busy && m_t == 2) hit = 1'b1;
      n++;
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL calc_wait: CALC not reached within 50 cycles, required entry");
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_quotient", 64'(rsp_q), 64'd0);
    chk("midrst_remainder", 64'(rsp_r), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    req_q[0].delete();
    req_q[1].delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_op(0, 32'd50, 32'd5);
    push_op(1, 32'd9, 32'd2);
    wait_done(100);

    push_op(0, 32'hFFFF_FFFF, 32'd1);
    push_op(1, 32'd5, 32'hFFFF_FFFF);
    wait_done(100);

    rsp_mode = 2;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(1, 100));
        1: b = 32'd0;
        2: b = $urandom;
        default: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 50)); end
      endcase
      push_op(int'($urandom_range(0, 1)), a, b);
    end
    wait_done(4000);
    rsp_mode = 1;

    c1_op(0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    c1_op(1, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Sequential front-end for the shared `divider_unsigned` datapath. It arbitrates round-robin between `NUM_REQ` requesters and registers the winner's operands. It holds them stable for `MC_CYCLES` clocks so the combinational divider can be constrained as a multicycle path, then returns the registered result over a valid/ready response channel. It sits between the execute-stage requesters (e.g. integer pipe, CSR/debug path) and the single divider instance.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `MC_CYCLES`, default 4: clocks the divider inputs are held before the result is sampled; must be ≥ 1.

Ports:
- `i_clk`, input, 1: the single clock; all state updates on the rising edge.
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_req_valid`, input, `NUM_REQ`: request valid, one bit per requester.
- `o_req_ready`, output, `NUM_REQ`: request accepted; one-hot or zero.
- `i_req_dividend`, input, `NUM_REQ*32`: packed dividends; requester i occupies bits `[32*i+31:32*i]`.
- `i_req_divisor`, input, `NUM_REQ*32`: packed divisors, same packing.
- `o_rsp_valid`, output, `NUM_REQ`: response valid to the granted requester; one-hot or zero.
- `i_rsp_ready`, input, `NUM_REQ`: response taken.
- `o_rsp_quotient`, output, 32: quotient, shared bus.
- `o_rsp_remainder`, output, 32: remainder, shared bus.
- `o_busy`, output, 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - Winner `g` = first asserted `i_req_valid` searching from `last+1` modulo `NUM_REQ`.
  - `o_req_ready[g]` = 1 combinationally; all other ready bits are 0.
  - On handshake: latch `i_req_dividend[g]` and `i_req_divisor[g]` into the operand registers, latch `g` into the grant register, load `cnt = MC_CYCLES-1`, go to CALC.
  - With no valid request: stay in IDLE; all ready bits are 0.
- **CALC**
  - The operand registers drive the divider; no ready is asserted.
  - If `cnt == 0`: latch the divider quotient and remainder into the result registers and go to RESP. Otherwise decrement `cnt`.
- **RESP**
  - `o_rsp_valid[grant]` = 1; the result registers drive `o_rsp_quotient` and `o_rsp_remainder`.
  - On `i_rsp_ready[grant]`: set `last = grant` and go to IDLE.
  - `i_rsp_ready` bits other than `grant` are ignored.
- **Round-robin**: `last` resets to `NUM_REQ-1`, so requester 0 wins first after reset. The pointer updates only on response completion.
- **Divide by zero**: no special case. The datapath yields quotient 0xFFFFFFFF and remainder = dividend, which are passed through unchanged.
- **Requester obligations**: hold valid and operands stable until ready. Dropping valid before ready is a protocol violation.
- **Reset** (asynchronous assert, at any time including mid-CALC or mid-RESP):
  - State returns to IDLE; `cnt`, operand, result and grant registers clear; `last` returns to `NUM_REQ-1`.
  - Any in-flight operation is discarded and no response is issued.
- **Output reset values**: `o_req_ready` = 0, `o_rsp_valid` = 0, `o_rsp_quotient` = 0, `o_rsp_remainder` = 0, `o_busy` = 0.

## Timing
- Accept edge `k`; CALC occupies edges `k+1` .. `k+MC_CYCLES`. `o_rsp_valid` is high from edge `k+MC_CYCLES` onward. Latency = `MC_CYCLES` cycles from accept to response valid.
- Response-fire edge `r` returns to IDLE; the earliest next accept is edge `r+1`. Peak throughput is one operation per `MC_CYCLES+2` cycles.
- `o_rsp_valid`, `o_rsp_quotient` and `o_rsp_remainder` stay stable under backpressure until the response handshake.
- `o_req_ready` depends combinationally on `i_req_valid` and state only; no path from the divider to ready.
- The divider's input→output path is a `MC_CYCLES`-cycle multicycle path. The operand registers change only on accept edges.

## Structure
- Package `div_pkg` holds `DIV_W = 32` and the FSM state enum (IDLE, CALC, RESP).
- One sub-module: an instance of `divider_unsigned` fed by the operand registers.
- The round-robin pick is a local function; it is not a separate module.

## Test plan
- **Single request**: `MC_CYCLES=4`, req0 100/7 → `o_rsp_valid[0]` exactly 4 cycles after accept; q=14, r=2; `o_busy` high from accept through response.
- **Fairness**: after reset, both requesters hold 20/3 and 9/2 continuously → service order req0 (6, 2), req1 (4, 1), req0, req1, … strictly alternating.
- **Divide by zero**: req1 0x12345678/0 → q=0xFFFFFFFF, r=0x12345678; no hang, normal return to IDLE.
- **Backpressure**: `i_rsp_ready[0]` held low 5 cycles while req1 is valid → response data stable; `o_req_ready[1]` = 0 throughout; req1 accepted on the cycle after the req0 response fires.
- **Reset mid-CALC**: assert `i_rst_n` low 2 cycles into CALC → all outputs 0 immediately and no response afterward. The next request 50/5 then completes with q=10, r=0, and req0 has priority.
- **Extremes**: 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0. 5/0xFFFFFFFF → q=0, r=5. `MC_CYCLES=1` → response valid on the edge after accept.
